// File: rtl/clock_port_master_if.sv
// Requester handshake plus the clock-port strobe/address outputs of clock_port_master.
// CP_D is kept off the interface so its tristate driver sits directly on a module port.
interface clock_port_master_if;
  logic       cpm_req;
  logic       cpm_ack;
  logic       cpm_write;
  logic [3:0] cpm_address;
  logic [3:0] cpm_data_in;
  logic [3:0] cpm_data_out;
  logic       busy;
  logic       CP_RTC_CS_n;
  logic       CP_RD_n;
  logic       CP_WR_n;
  logic [3:0] CP_A;

  modport master (
    input  cpm_req, cpm_write, cpm_address, cpm_data_in,
    output cpm_ack, cpm_data_out, busy, CP_RTC_CS_n, CP_RD_n, CP_WR_n, CP_A
  );

  modport slave (
    output cpm_req, cpm_write, cpm_address, cpm_data_in,
    input  cpm_ack, cpm_data_out, busy, CP_RTC_CS_n, CP_RD_n, CP_WR_n, CP_A
  );
endinterface

// File: rtl/clock_port_master.sv
// Clock-port (RTC) bus initiator: turns a toggle request into a timed CS/RD/WR cycle
// with programmable setup, strobe and hold lengths; every output comes from a register.
module clock_port_master #(
  parameter logic [7:0] SETUP_CYCLES  = 8'd10,
  parameter logic [7:0] STROBE_CYCLES = 8'd40,
  parameter logic [7:0] HOLD_CYCLES   = 8'd10
) (
  input  logic                       clk200,
  input  logic                       reset,
  clock_port_master_if.master        bus,
  inout  wire  [3:0]                 CP_D
);

  // A phase of N cycles counts N-1 down to 0; a zero parameter still gives one cycle.
  localparam logic [7:0] SETUP_LOAD  = (SETUP_CYCLES  == 8'd0) ? 8'd0 : SETUP_CYCLES  - 8'd1;
  localparam logic [7:0] STROBE_LOAD = (STROBE_CYCLES == 8'd0) ? 8'd0 : STROBE_CYCLES - 8'd1;
  localparam logic [7:0] HOLD_LOAD   = (HOLD_CYCLES   == 8'd0) ? 8'd0 : HOLD_CYCLES   - 8'd1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t     state, state_next;
  logic [7:0] count, count_next;
  logic       req_latched, req_latched_next;
  logic       write_latched, write_latched_next;
  logic       cs_n, cs_n_next;
  logic       rd_n, rd_n_next;
  logic       wr_n, wr_n_next;
  logic [3:0] addr, addr_next;
  logic [3:0] d_out, d_out_next;
  logic       d_oe, d_oe_next;
  logic       ack, ack_next;
  logic [3:0] data_out, data_out_next;
  logic       busy_reg, busy_next;

  always_ff @(posedge clk200) begin
    if (reset) begin
      state         <= IDLE;
      count         <= 8'd0;
      req_latched   <= 1'b0;
      write_latched <= 1'b0;
      cs_n          <= 1'b1;
      rd_n          <= 1'b1;
      wr_n          <= 1'b1;
      addr          <= 4'd0;
      d_out         <= 4'd0;
      d_oe          <= 1'b0;
      ack           <= 1'b0;
      data_out      <= 4'd0;
      busy_reg      <= 1'b0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      req_latched   <= req_latched_next;
      write_latched <= write_latched_next;
      cs_n          <= cs_n_next;
      rd_n          <= rd_n_next;
      wr_n          <= wr_n_next;
      addr          <= addr_next;
      d_out         <= d_out_next;
      d_oe          <= d_oe_next;
      ack           <= ack_next;
      data_out      <= data_out_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next         = state;
    count_next         = count;
    req_latched_next   = req_latched;
    write_latched_next = write_latched;
    cs_n_next          = cs_n;
    rd_n_next          = rd_n;
    wr_n_next          = wr_n;
    addr_next          = addr;
    d_out_next         = d_out;
    d_oe_next          = d_oe;
    ack_next           = ack;
    data_out_next      = data_out;
    busy_next          = busy_reg;

    case (state)
      IDLE: begin
        if (bus.cpm_req != ack) begin
          req_latched_next   = bus.cpm_req;
          write_latched_next = bus.cpm_write;
          addr_next          = bus.cpm_address;
          d_out_next         = bus.cpm_data_in;
          d_oe_next          = bus.cpm_write;
          cs_n_next          = 1'b0;
          busy_next          = 1'b1;
          count_next         = SETUP_LOAD;
          state_next         = SETUP;
        end
      end
      SETUP: begin
        if (count == 8'd0) begin
          if (write_latched) wr_n_next = 1'b0;
          else               rd_n_next = 1'b0;
          count_next = STROBE_LOAD;
          state_next = STROBE;
        end else begin
          count_next = count - 8'd1;
        end
      end
      STROBE: begin
        if (count == 8'd0) begin
          // Sampled on the edge that raises RD_n, while the responder still drives.
          if (!write_latched) data_out_next = CP_D;
          rd_n_next  = 1'b1;
          wr_n_next  = 1'b1;
          count_next = HOLD_LOAD;
          state_next = HOLD;
        end else begin
          count_next = count - 8'd1;
        end
      end
      HOLD: begin
        if (count == 8'd0) begin
          cs_n_next  = 1'b1;
          d_oe_next  = 1'b0;
          busy_next  = 1'b0;
          ack_next   = req_latched;
          state_next = IDLE;
        end else begin
          count_next = count - 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign CP_D             = d_oe ? d_out : 4'bz;
  assign bus.cpm_ack      = ack;
  assign bus.cpm_data_out = data_out;
  assign bus.busy         = busy_reg;
  assign bus.CP_RTC_CS_n  = cs_n;
  assign bus.CP_RD_n      = rd_n;
  assign bus.CP_WR_n      = wr_n;
  assign bus.CP_A         = addr;

endmodule

// File: tb/tb_clock_port_master.sv
// Directed bench for clock_port_master: a default-timed instance driven from a vector
// table, and a minimum-timing instance checked with a short hand-written sequence.
`timescale 1ns/1ps
module tb_clock_port_master;

  logic clk200 = 1'b0;
  logic reset;
  always #2.5 clk200 = ~clk200;

  clock_port_master_if bus_a ();
  clock_port_master_if bus_b ();
  wire  [3:0] cp_d_a;
  wire  [3:0] cp_d_b;
  logic       probe_en;
  logic [3:0] probe_val;

  localparam logic [3:0] RESP_A = 4'h5;
  localparam logic [3:0] RESP_B = 4'h9;

  // Model responders drive the data bus only while RD_n is low; the probe detects a floating bus.
  assign cp_d_a = !bus_a.CP_RD_n ? RESP_A : (probe_en ? probe_val : 4'bz);
  assign cp_d_b = !bus_b.CP_RD_n ? RESP_B : 4'bz;

  clock_port_master dut_a (
    .clk200 (clk200),
    .reset  (reset),
    .bus    (bus_a),
    .CP_D   (cp_d_a)
  );

  clock_port_master #(
    .SETUP_CYCLES  (8'd0),
    .STROBE_CYCLES (8'd1),
    .HOLD_CYCLES   (8'd0)
  ) dut_b (
    .clk200 (clk200),
    .reset  (reset),
    .bus    (bus_b),
    .CP_D   (cp_d_b)
  );

  typedef struct {
    int         run;
    int         e;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic [3:0] a;
    logic       chk_d;
    logic [3:0] d;
    logic       ack;
    logic       busy;
    logic       chk_dout;
    logic [3:0] dout;
  } vec_t;

  vec_t vecs[$];

  logic       cs_log   [0:255];
  logic       rd_log   [0:255];
  logic       wr_log   [0:255];
  logic [3:0] a_log    [0:255];
  logic [3:0] d_log    [0:255];
  logic       ack_log  [0:255];
  logic       busy_log [0:255];
  logic [3:0] dout_log [0:255];

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%h, required 0x%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic write, input logic [3:0] address, input logic [3:0] data);
    @(negedge clk200);
    bus_a.cpm_write   = write;
    bus_a.cpm_address = address;
    bus_a.cpm_data_in = data;
    bus_a.cpm_req     = ~bus_a.cpm_req;
  endtask

  // Edge e of the log is the e-th rising edge after the request toggle.
  task automatic run_edges(input int n, input int toggle_at, input int alter_at);
    for (int e = 0; e < n; e++) begin
      @(posedge clk200);
      #1;
      cs_log[e]   = bus_a.CP_RTC_CS_n;
      rd_log[e]   = bus_a.CP_RD_n;
      wr_log[e]   = bus_a.CP_WR_n;
      a_log[e]    = bus_a.CP_A;
      d_log[e]    = cp_d_a;
      ack_log[e]  = bus_a.cpm_ack;
      busy_log[e] = bus_a.busy;
      dout_log[e] = bus_a.cpm_data_out;
      if (e == toggle_at) bus_a.cpm_req = ~bus_a.cpm_req;
      if (e == alter_at) begin
        bus_a.cpm_address = 4'hC;
        bus_a.cpm_data_in = 4'h5;
      end
    end
  endtask

  task automatic apply_table(input int run);
    foreach (vecs[i]) begin
      if (vecs[i].run == run) begin
        string tag;
        int    e;
        e   = vecs[i].e;
        tag = $sformatf("run%0d_e%0d", run, e);
        checkOutput({tag, "_cs_n"}, 8'(cs_log[e]),   8'(vecs[i].cs_n));
        checkOutput({tag, "_rd_n"}, 8'(rd_log[e]),   8'(vecs[i].rd_n));
        checkOutput({tag, "_wr_n"}, 8'(wr_log[e]),   8'(vecs[i].wr_n));
        checkOutput({tag, "_cp_a"}, 8'(a_log[e]),    8'(vecs[i].a));
        checkOutput({tag, "_ack"},  8'(ack_log[e]),  8'(vecs[i].ack));
        checkOutput({tag, "_busy"}, 8'(busy_log[e]), 8'(vecs[i].busy));
        if (vecs[i].chk_d)    checkOutput({tag, "_cp_d"}, 8'(d_log[e]),    8'(vecs[i].d));
        if (vecs[i].chk_dout) checkOutput({tag, "_dout"}, 8'(dout_log[e]), 8'(vecs[i].dout));
      end
    end
  endtask

  task automatic check_released(input string name);
    probe_en  = 1'b1;
    probe_val = 4'h6;
    #1;
    checkOutput(name, 8'(cp_d_a), 8'h06);
    probe_en  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    logic       b_rd   [0:5];
    logic       b_cs   [0:5];
    logic       b_ack  [0:5];
    logic       b_busy [0:5];
    logic [3:0] b_dout [0:5];
    logic [3:0] b_d    [0:5];

    reset     = 1'b1;
    probe_en  = 1'b0;
    probe_val = 4'h0;
    bus_a.cpm_req = 1'b0; bus_a.cpm_write = 1'b0; bus_a.cpm_address = 4'h0; bus_a.cpm_data_in = 4'h0;
    bus_b.cpm_req = 1'b0; bus_b.cpm_write = 1'b0; bus_b.cpm_address = 4'h0; bus_b.cpm_data_in = 4'h0;

    //              run  e    cs    rd    wr    a      chkd  d      ack   busy  chko  dout
    vecs.push_back('{0,   0, 1'b0, 1'b1, 1'b1, 4'h3, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{0,   9, 1'b0, 1'b1, 1'b1, 4'h3, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{0,  10, 1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{0,  25, 1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{0,  49, 1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{0,  50, 1'b0, 1'b1, 1'b1, 4'h3, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{0,  59, 1'b0, 1'b1, 1'b1, 4'h3, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{0,  60, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0});
    vecs.push_back('{0,  61, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0});
    vecs.push_back('{1,   0, 1'b0, 1'b1, 1'b1, 4'h7, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{1,  10, 1'b0, 1'b1, 1'b0, 4'h7, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{1,  50, 1'b0, 1'b1, 1'b1, 4'h7, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{1,  60, 1'b1, 1'b1, 1'b1, 4'h7, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0});
    vecs.push_back('{2,   0, 1'b0, 1'b1, 1'b1, 4'hD, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{2,   9, 1'b0, 1'b1, 1'b1, 4'hD, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{2,  10, 1'b0, 1'b0, 1'b1, 4'hD, 1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{2,  49, 1'b0, 1'b0, 1'b1, 4'hD, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 4'h0});
    vecs.push_back('{2,  50, 1'b0, 1'b1, 1'b1, 4'hD, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h5});
    vecs.push_back('{2,  60, 1'b1, 1'b1, 1'b1, 4'hD, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h5});
    vecs.push_back('{3,  59, 1'b0, 1'b1, 1'b1, 4'h3, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{3,  60, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0});
    vecs.push_back('{3,  61, 1'b0, 1'b1, 1'b1, 4'h3, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{3,  70, 1'b0, 1'b1, 1'b1, 4'h3, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{3,  71, 1'b0, 1'b1, 1'b0, 4'h3, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{3, 120, 1'b0, 1'b1, 1'b1, 4'h3, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{3, 121, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h5});

    repeat (3) @(posedge clk200);
    @(negedge clk200);
    reset = 1'b0;
    checkOutput("reset_cs_n",   8'(bus_a.CP_RTC_CS_n), 8'h01);
    checkOutput("reset_rd_n",   8'(bus_a.CP_RD_n),     8'h01);
    checkOutput("reset_wr_n",   8'(bus_a.CP_WR_n),     8'h01);
    checkOutput("reset_cp_a",   8'(bus_a.CP_A),        8'h00);
    checkOutput("reset_ack",    8'(bus_a.cpm_ack),     8'h00);
    checkOutput("reset_busy",   8'(bus_a.busy),        8'h00);
    checkOutput("reset_dout",   8'(bus_a.cpm_data_out), 8'h00);
    checkOutput("reset_b_cs_n", 8'(bus_b.CP_RTC_CS_n), 8'h01);
    check_released("reset_cp_d_released");

    // Write with address/data changed at edge 20; the latched values must hold.
    applyStimulus(1'b1, 4'h3, 4'hA);
    run_edges(62, -1, 20);
    apply_table(0);
    bad = 0;
    for (int e = 0; e < 60; e++) if (a_log[e] !== 4'h3 || d_log[e] !== 4'hA) bad++;
    checkOutput("write_addr_data_held_bad_edges", 8'(bad), 8'h00);
    bad = 0;
    for (int e = 0; e < 62; e++) if (rd_log[e] !== 1'b1) bad++;
    checkOutput("write_rd_n_low_edges", 8'(bad), 8'h00);
    check_released("write_cp_d_released");

    // Reset landing in the strobe phase of a write; requester toggle returns to 0.
    applyStimulus(1'b1, 4'h6, 4'h3);
    run_edges(20, -1, -1);
    checkOutput("rst_test_in_strobe_wr_n", 8'(wr_log[19]), 8'h00);
    reset         = 1'b1;
    bus_a.cpm_req = 1'b0;
    probe_en      = 1'b1;
    probe_val     = 4'h6;
    @(posedge clk200);
    #1;
    checkOutput("rst_mid_cs_n", 8'(bus_a.CP_RTC_CS_n), 8'h01);
    checkOutput("rst_mid_wr_n", 8'(bus_a.CP_WR_n),     8'h01);
    checkOutput("rst_mid_rd_n", 8'(bus_a.CP_RD_n),     8'h01);
    checkOutput("rst_mid_ack",  8'(bus_a.cpm_ack),     8'h00);
    checkOutput("rst_mid_busy", 8'(bus_a.busy),        8'h00);
    checkOutput("rst_mid_cp_d_released", 8'(cp_d_a),   8'h06);
    probe_en = 1'b0;
    @(negedge clk200);
    reset = 1'b0;

    applyStimulus(1'b1, 4'h7, 4'h1);
    run_edges(62, -1, -1);
    apply_table(1);
    check_released("post_reset_cp_d_released");

    // Read; cpm_data_in is nonzero so any drive of CP_D by the block shows as contention.
    applyStimulus(1'b0, 4'hD, 4'hA);
    run_edges(62, -1, -1);
    apply_table(2);
    bad = 0;
    for (int e = 10; e < 50; e++) if (d_log[e] !== RESP_A) bad++;
    checkOutput("read_cp_d_undisturbed_bad_edges", 8'(bad), 8'h00);
    bad = 0;
    for (int e = 0; e < 62; e++) if (wr_log[e] !== 1'b1) bad++;
    checkOutput("read_wr_n_low_edges", 8'(bad), 8'h00);

    // Back-to-back: second toggle while the first write is still in its strobe.
    applyStimulus(1'b1, 4'h3, 4'hA);
    run_edges(125, 30, -1);
    apply_table(3);

    // Minimum timing instance, read: strobe low only between edges 1 and 2, ack at 3.
    @(negedge clk200);
    bus_b.cpm_write   = 1'b0;
    bus_b.cpm_address = 4'h2;
    bus_b.cpm_data_in = 4'hA;
    bus_b.cpm_req     = ~bus_b.cpm_req;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk200);
      #1;
      b_rd[e]   = bus_b.CP_RD_n;
      b_cs[e]   = bus_b.CP_RTC_CS_n;
      b_ack[e]  = bus_b.cpm_ack;
      b_busy[e] = bus_b.busy;
      b_dout[e] = bus_b.cpm_data_out;
      b_d[e]    = cp_d_b;
    end
    checkOutput("min_e0_rd_n", 8'(b_rd[0]),   8'h01);
    checkOutput("min_e0_cs_n", 8'(b_cs[0]),   8'h00);
    checkOutput("min_e0_busy", 8'(b_busy[0]), 8'h01);
    checkOutput("min_e1_rd_n", 8'(b_rd[1]),   8'h00);
    checkOutput("min_e1_cp_d", 8'(b_d[1]),    8'(RESP_B));
    checkOutput("min_e2_rd_n", 8'(b_rd[2]),   8'h01);
    checkOutput("min_e2_ack",  8'(b_ack[2]),  8'h00);
    checkOutput("min_e2_dout", 8'(b_dout[2]), 8'(RESP_B));
    checkOutput("min_e3_ack",  8'(b_ack[3]),  8'h01);
    checkOutput("min_e3_cs_n", 8'(b_cs[3]),   8'h01);
    checkOutput("min_e3_busy", 8'(b_busy[3]), 8'h00);
    checkOutput("min_e5_rd_n", 8'(b_rd[5]),   8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/clock_port_master.md
# clock_port_master

Initiator side of the 4-bit Amiga clock-port (RTC) bus, clocked from clk200. Converts a toggle-handshake request (read/write, 4-bit register address, 4-bit data) from on-chip logic into a fully timed CS/RD/WR bus cycle. The strobe phases are programmable. On reads, the block returns the sampled nibble. It exercises clock-port responders in-system and drives external RTC-style peripherals.

## Interface
Parameters:
- SETUP_CYCLES, 10, clk200 cycles with CS asserted and address/write-data valid before the strobe; 8-bit, 0 treated as 1
- STROBE_CYCLES, 40, clk200 cycles RD_n/WR_n held low; 8-bit, 0 treated as 1
- HOLD_CYCLES, 10, clk200 cycles after strobe release with CS, address and write data held; 8-bit, 0 treated as 1

Ports:
- clk200  input  1  system clock; one clock only
- reset  input  1  synchronous, active-high reset
- cpm_req  input  1  request toggle; a request is pending when cpm_req != cpm_ack
- cpm_ack  output  1  acknowledge toggle; set equal to the latched cpm_req when the transaction ends
- cpm_write  input  1  1 = write, 0 = read; sampled with the request
- cpm_address  input  4  register address; sampled with the request
- cpm_data_in  input  4  write nibble; sampled with the request
- cpm_data_out  output  4  read nibble; valid from the ack toggle until the next read completes
- busy  output  1  high from request acceptance until return to IDLE
- CP_RTC_CS_n  output  1  chip select, active low
- CP_RD_n  output  1  read strobe, active low
- CP_WR_n  output  1  write strobe, active low
- CP_A  output  4  bus address, drives CP_A[5:2] of the responder
- CP_D  inout  4  bus data; driven only during write cycles, high-Z otherwise

## Operation
- All outputs are registered. CP_D is driven from a registered output-enable and data pair.
- Reset values:
  - CP_RTC_CS_n=1, CP_RD_n=1, CP_WR_n=1, CP_A=0
  - CP_D high-Z
  - cpm_ack=0, cpm_data_out=0, busy=0
  - state IDLE, counter 0
- States are IDLE, SETUP, STROBE, HOLD. The single 8-bit down-counter is loaded with (param==0 ? 0 : param-1) on each state entry.
- IDLE:
  - On the first edge where cpm_req != cpm_ack, latch cpm_req, cpm_write, cpm_address and cpm_data_in.
  - Set CP_A = address and CS_n = 0. If writing, enable CP_D = data.
  - Set busy = 1 and enter SETUP.
- SETUP: when the counter reaches 0, assert RD_n=0 (read) or WR_n=0 (write) and enter STROBE. Otherwise decrement.
- STROBE:
  - When the counter reaches 0, deassert the strobe and enter HOLD.
  - On a read, capture CP_D into cpm_data_out on the same edge, before the strobe rises.
- HOLD:
  - When the counter reaches 0: CS_n=1, release CP_D, CP_A unchanged, busy=0, cpm_ack <= latched req. Enter IDLE.
- Inputs are ignored outside IDLE. A further cpm_req toggle during a transaction is not lost: after return, req != ack again, so it starts a new transaction (toggle-parity semantics, as for the emu handshakes).
- A double toggle while busy nets to no pending request; this is the requester's responsibility.
- RD_n and WR_n are never low simultaneously. Neither is ever low while CS_n is high.
- cpm_write=0 never drives CP_D.
- Reset mid-transaction:
  - The bus is released on the reset edge (all strobes high, CS_n high, CP_D high-Z).
  - The transaction is discarded and cpm_ack=0. The requester's toggle must also be reset.

## Timing
- Edge 0 is the first edge with req != ack in IDLE. With S, P, H the effective phase lengths (min 1):
  - CS_n falls and CP_A/CP_D become valid at edge 0.
  - The strobe falls at edge S.
  - The strobe rises, and read data is captured, at edge S+P.
  - CS_n rises, CP_D releases, busy falls and cpm_ack toggles at edge S+P+H.
- Defaults give 10/40/10: a 200 ns strobe, and ack at cycle 60 (300 ns).
- At least one IDLE cycle separates transactions, so CS_n is high for ≥1 cycle between back-to-back accesses.
- Read data is sampled without a synchronizer. The responder must hold CP_D stable for ≥2 cycles before strobe end, which the defaults guarantee against the existing responder's 3-cycle synchronized detection.

## Test plan
- Write: req toggle, write=1, addr=0x3, data=0xA, defaults.
  - Required: CS_n low at edge 0; WR_n low edges 10–50; CP_A=3 and CP_D=0xA throughout; CP_D Z after edge 60; ack toggles at 60; RD_n stays 1.
- Read: model responder drives 0x5 while RD_n low, addr=0xD.
  - Required: cpm_data_out=0x5 at ack toggle (edge 60); CP_D never driven by the block; WR_n stays 1.
- Back-to-back: second toggle issued at edge 30 of a write.
  - Required: the first completes at 60; the second latches at 61 with CS_n high for exactly edge 60–61; second ack at 121.
- Reset asserted during STROBE of a write.
  - Required: next edge CS_n=1, WR_n=1, CP_D Z, ack=0, busy=0; a new request after reset completes normally.
- Parameters SETUP=0, STROBE=1, HOLD=0, read.
  - Required: strobe low for exactly edge 1–2; ack at edge 3.
- Input change during a transaction (address/data altered at edge 20).
  - Required: CP_A and CP_D keep the latched values until edge 60.
